coax_line_ctrl: RTL and testbench

Half-duplex line controller for the 3270 coax interface. Sits between the host-side command logic and the `coax_tx`/`coax_rx` pair, and owns the single shared coax line. It grants transmit access, gates the receiver while we drive the line, enforces the turnaround gap, and times out missing responses. It also applies a post-receive holdoff before the next transmit.

---
 rtl/coax_pkg.sv | 31 +++
 rtl/coax_bit_timer.sv | 35 +++
 rtl/coax_line_ctrl.sv | 173 +++++++++++++++++
 tb/tb_coax_line_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_pkg.sv
// -----------------------------------------------------------------------------
// coax_pkg
// Shared definitions for the 3270 coax line controller:
//   - coax_state_e : line controller state encoding
//   - DEF_*        : default bit-time constants
//   - max3()       : helper used to size the shared bit timer
// -----------------------------------------------------------------------------
package coax_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_TX         = 3'd2,
        ST_TURNAROUND = 3'd3,
        ST_WAIT       = 3'd4,
        ST_RX         = 3'd5,
        ST_HOLDOFF    = 3'd6
    } coax_state_e;

    localparam int DEF_CLOCKS_PER_BIT        = 16;
    localparam int DEF_TURNAROUND_BITS       = 4;
    localparam int DEF_RESPONSE_TIMEOUT_BITS = 64;
    localparam int DEF_HOLDOFF_BITS          = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/coax_bit_timer.sv
// -----------------------------------------------------------------------------
// coax_bit_timer
// Loadable down-counter shared by the timed line-controller states.
// Ports:
//   clk          : system clock
//   reset_n      : synchronous active-low reset (count cleared)
//   load_i       : load load_value_i this cycle
//   load_value_i : value loaded (cycles-in-state minus one)
//   done_o       : count has reached zero; the counter stops there
// -----------------------------------------------------------------------------
module coax_bit_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/coax_line_ctrl.sv
// -----------------------------------------------------------------------------
// coax_line_ctrl
// Half-duplex owner of the shared 3270 coax line: grants transmit access,
// gates the receiver while we drive, enforces the turnaround gap, times out
// missing responses and holds off transmit after a receive.
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   tx_req          : host transmit request (level, held until tx_grant)
//   expect_response : latched at grant; opens a response window after TX
//   tx_active       : coax_tx is driving the line
//   rx_active       : coax_rx is not idle
//   rx_error        : coax_rx error indication
//   tx_grant        : one-cycle pulse starting coax_tx
//   rx_enable       : 0 holds coax_rx in reset
//   busy            : controller not idle
//   timeout         : one-cycle pulse when the response window expires
//   line_error      : one-cycle pulse on the first rx_error of a receive
// Optional build macro COAX_LINE_CTRL_STATS_EN adds saturating 8-bit
// counters timeout_count and error_count.
// All outputs are registered from the current state, so they trail the
// state register by one cycle.
// -----------------------------------------------------------------------------
module coax_line_ctrl
    import coax_pkg::*;
#(
    parameter int CLOCKS_PER_BIT        = DEF_CLOCKS_PER_BIT,
    parameter int TURNAROUND_BITS       = DEF_TURNAROUND_BITS,
    parameter int RESPONSE_TIMEOUT_BITS = DEF_RESPONSE_TIMEOUT_BITS,
    parameter int HOLDOFF_BITS          = DEF_HOLDOFF_BITS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_req,
    input  logic       expect_response,
    input  logic       tx_active,
    input  logic       rx_active,
    input  logic       rx_error,
    output logic       tx_grant,
    output logic       rx_enable,
    output logic       busy,
    output logic       timeout,
`ifdef COAX_LINE_CTRL_STATS_EN
    output logic [7:0] timeout_count,
    output logic [7:0] error_count,
`endif
    output logic       line_error
);

    localparam int TA_CYCLES = TURNAROUND_BITS * CLOCKS_PER_BIT;
    localparam int RT_CYCLES = RESPONSE_TIMEOUT_BITS * CLOCKS_PER_BIT;
    localparam int HO_CYCLES = HOLDOFF_BITS * CLOCKS_PER_BIT;
    localparam int CNT_W     = $clog2(max3(TA_CYCLES, RT_CYCLES, HO_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'(TA_CYCLES - 1);
    localparam logic [CNT_W-1:0] RT_LOAD = CNT_W'(RT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HO_LOAD = CNT_W'(HO_CYCLES - 1);

    coax_state_e      state_q, state_d;
    logic             expect_q;        // expect_response latched at grant
    logic             tx_elapsed_q;    // set from the second TX cycle onwards
    logic             err_seen_q;      // an error was already reported this receive
    logic             timeout_pend_q;  // WAIT expired last cycle
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_done;

    coax_bit_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (tmr_load),
        .load_value_i (tmr_value),
        .done_o       (tmr_done)
    );

    // Next state and timer load. The timer is loaded on the transition into
    // a timed state so the state lasts exactly its load value plus one.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state_q)
            ST_IDLE: begin
                // An unsolicited receive wins over a simultaneous request.
                if (rx_active)   state_d = ST_RX;
                else if (tx_req) state_d = ST_GRANT;
            end
            ST_GRANT: state_d = ST_TX;
            ST_TX: begin
                if (tx_elapsed_q && !tx_active) begin
                    state_d   = ST_TURNAROUND;
                    tmr_load  = 1'b1;
                    tmr_value = TA_LOAD;
                end
            end
            ST_TURNAROUND: begin
                if (tmr_done) begin
                    if (expect_q) begin
                        state_d   = ST_WAIT;
                        tmr_load  = 1'b1;
                        tmr_value = RT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                // Receive wins even on the expiry cycle.
                if (rx_active)     state_d = ST_RX;
                else if (tmr_done) state_d = ST_IDLE;
            end
            ST_RX: begin
                if (!rx_active) begin
                    state_d   = ST_HOLDOFF;
                    tmr_load  = 1'b1;
                    tmr_value = HO_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (rx_active)     state_d = ST_RX;
                else if (tmr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            expect_q       <= 1'b0;
            tx_elapsed_q   <= 1'b0;
            err_seen_q     <= 1'b0;
            timeout_pend_q <= 1'b0;
            tx_grant       <= 1'b0;
            rx_enable      <= 1'b0;
            busy           <= 1'b0;
            timeout        <= 1'b0;
            line_error     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_elapsed_q <= (state_q == ST_TX);
            if (state_q == ST_GRANT) expect_q <= expect_response;

            tx_grant  <= (state_q == ST_GRANT);
            rx_enable <= (state_q == ST_IDLE) || (state_q == ST_WAIT) ||
                         (state_q == ST_RX)   || (state_q == ST_HOLDOFF);
            busy      <= (state_q != ST_IDLE);

            // WAIT only falls back to IDLE on expiry, so this marks a timeout;
            // the extra stage keeps timeout aligned with the other outputs.
            timeout_pend_q <= (state_q == ST_WAIT) && tmr_done && !rx_active;
            timeout        <= timeout_pend_q;

            line_error <= (state_q == ST_RX) && rx_error && !err_seen_q;
            if (state_q != ST_RX) err_seen_q <= 1'b0;
            else if (rx_error)    err_seen_q <= 1'b1;
        end
    end

`ifdef COAX_LINE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_count <= '0;
            error_count   <= '0;
        end else begin
            if (timeout && timeout_count != 8'hFF)  timeout_count <= timeout_count + 8'd1;
            if (line_error && error_count != 8'hFF) error_count   <= error_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coax_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coax_line_ctrl
// Directed bench for coax_line_ctrl at default parameters: a cycle table for
// reset/grant/mid-operation reset, then hand-written multi-cycle sequences
// for turnaround, response window, timeout, error suppression, holdoff and
// the simultaneous-event corner cases.
// -----------------------------------------------------------------------------
module tb_coax_line_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tx_req = 1'b0;
    logic expect_response = 1'b0;
    logic tx_active = 1'b0;
    logic rx_active = 1'b0;
    logic rx_error = 1'b0;
    logic tx_grant, rx_enable, busy, timeout, line_error;
`ifdef COAX_LINE_CTRL_STATS_EN
    logic [7:0] timeout_count, error_count;
`endif

    always #5 clk = ~clk;

    coax_line_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tx_req          (tx_req),
        .expect_response (expect_response),
        .tx_active       (tx_active),
        .rx_active       (rx_active),
        .rx_error        (rx_error),
        .tx_grant        (tx_grant),
        .rx_enable       (rx_enable),
        .busy            (busy),
        .timeout         (timeout),
`ifdef COAX_LINE_CTRL_STATS_EN
        .timeout_count   (timeout_count),
        .error_count     (error_count),
`endif
        .line_error      (line_error)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int grant_cnt = 0;
    int to_cnt    = 0;
    int le_cnt    = 0;

    typedef struct {
        logic rst_n, req, exp, txa, rxa, rxe;   // inputs
        logic g, en, b, to, le;                 // expected outputs after the edge
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_grant)   grant_cnt++;
        if (timeout)    to_cnt++;
        if (line_error) le_cnt++;
    endtask

    // which: 0 tx_grant, 1 rx_enable, 2 timeout, 3 not busy. n = ticks taken, -1 on expiry.
    task automatic wait_sig(input int which, input int limit, output int n);
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            tick();
            n++;
            case (which)
                0:       hit = tx_grant;
                1:       hit = rx_enable;
                2:       hit = timeout;
                default: hit = !busy;
            endcase
        end
        if (!hit) n = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, g0, t0, l0;
        bit seen;

        //             rst req exp txa rxa rxe | g  en b  to le
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // in reset
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0}; // rx_enable after release
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0}; // req sampled -> GRANT
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0}; // grant pulse, rx off
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0}; // -> TURNAROUND
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0}; // reset mid-turnaround
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0}; // pending req seen
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0}; // granted normally
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0}; // silent TX, cycle 1
        vecs[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0}; // silent TX, cycle 2

        for (int i = 0; i < 14; i++) begin
            reset_n = vecs[i].rst_n; tx_req = vecs[i].req; expect_response = vecs[i].exp;
            tx_active = vecs[i].txa; rx_active = vecs[i].rxa; rx_error = vecs[i].rxe;
            tick();
            check($sformatf("vec%0d_tx_grant", i),   tx_grant,   vecs[i].g);
            check($sformatf("vec%0d_rx_enable", i),  rx_enable,  vecs[i].en);
            check($sformatf("vec%0d_busy", i),       busy,       vecs[i].b);
            check($sformatf("vec%0d_timeout", i),    timeout,    vecs[i].to);
            check($sformatf("vec%0d_line_error", i), line_error, vecs[i].le);
        end

        // Clean restart
        tx_req = 0; tx_active = 0; rx_active = 0; rx_error = 0; expect_response = 0;
        reset_n = 0; tick(); reset_n = 1; tick();
        grant_cnt = 0; to_cnt = 0; le_cnt = 0;

        // A: basic transmit without response
        g0 = grant_cnt;
        tx_req = 1;
        wait_sig(0, 10, n);
        check("A_grant_latency", n, 2);
        check("A_rx_en_at_grant", rx_enable, 0);
        tx_req = 0; tx_active = 1;
        seen = 0;
        repeat (40) begin tick(); if (rx_enable) seen = 1; end
        check("A_rx_en_low_during_tx", seen, 0);
        tx_active = 0;
        tick();                                // edge that samples tx_active low
        wait_sig(1, 200, n);
        check("A_turnaround", n, 65);
        check("A_idle_busy", busy, 0);
        check("A_grant_pulses", grant_cnt - g0, 1);

        // B: response received, then tx_req during holdoff
        t0 = to_cnt;
        expect_response = 1; tx_req = 1;
        wait_sig(0, 10, n);
        tx_req = 0;
        wait_sig(1, 200, n);                   // rx_enable one cycle after WAIT entry
        check("B_silent_tx_to_wait", n, 67);
        repeat (98) tick();
        rx_active = 1;
        repeat (200) tick();
        check("B_rx_busy", busy, 1);
        check("B_rx_enable", rx_enable, 1);
        rx_active = 0;
        tick();                                // edge that samples rx_active low
        n = 0;
        repeat (10) begin tick(); n++; end
        expect_response = 0; tx_req = 1;
        wait_sig(0, 300, m);
        check("B_holdoff_gap", (m < 0) ? -1 : n + m, 130);
        check("B_no_timeout", to_cnt - t0, 0);
        tx_req = 0;
        wait_sig(3, 300, n);
        check("B_back_idle", n > 0, 1);

        // C: response timeout
        t0 = to_cnt;
        expect_response = 1; tx_req = 1;
        wait_sig(0, 10, n);
        tx_req = 0;
        wait_sig(1, 200, n);                   // WAIT entry + 1
        wait_sig(2, 1200, n);
        check("C_timeout_latency", n, 1024);   // 1025 cycles after WAIT entry
        check("C_timeout_idle", busy, 0);
        check("C_timeout_rx_enable", rx_enable, 1);
        repeat (20) tick();
        check("C_timeout_pulses", to_cnt - t0, 1);
        expect_response = 0;

        // D: three errors in one receive
        l0 = le_cnt;
        rx_active = 1; tick();
        rx_error = 1; tick();
        check("D_line_error_latency", line_error, 1);
        rx_error = 0; tick();
        check("D_line_error_one_cycle", line_error, 0);
        rx_error = 1; tick(); rx_error = 0; tick();
        rx_error = 1; tick(); rx_error = 0;
        repeat (3) tick();
        check("D_line_error_count", le_cnt - l0, 1);
`ifdef COAX_LINE_CTRL_STATS_EN
        check("D_error_count", error_count, 1);
        check("C_timeout_count", timeout_count, 1);
`endif
        rx_active = 0;
        wait_sig(3, 300, n);
        check("D_back_idle", n > 0, 1);

        // E: rx_active and tx_req in the same IDLE cycle
        g0 = grant_cnt;
        rx_active = 1; tx_req = 1;
        repeat (20) tick();
        check("E_no_grant_in_rx", grant_cnt - g0, 0);
        check("E_rx_busy", busy, 1);
        check("E_rx_enable", rx_enable, 1);
        rx_active = 0;
        tick();
        wait_sig(0, 300, n);
        check("E_holdoff_gap", n, 130);
        check("E_grant_pulses", grant_cnt - g0, 1);
        tx_req = 0;
        wait_sig(3, 300, n);
        check("E_back_idle", n > 0, 1);

        // F: rx_active rises on the WAIT expiry cycle
        t0 = to_cnt;
        expect_response = 1; tx_req = 1;
        wait_sig(0, 10, n);
        tx_req = 0;
        wait_sig(1, 200, n);                   // WAIT entry + 1
        repeat (1022) tick();                  // now in the last WAIT cycle
        rx_active = 1;
        repeat (5) tick();
        check("F_rx_busy", busy, 1);
        check("F_rx_enable", rx_enable, 1);
        rx_active = 0; expect_response = 0;
        wait_sig(3, 300, n);
        check("F_back_idle", n > 0, 1);
        check("F_no_timeout", to_cnt - t0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
